// File: rtl/tx_framer.sv
// rtl/tx_framer.sv - packs a 32-bit message stream into fixed CHNL_ALIGN-word records
// Each record is a header word plus zero-padded payload, with idle-timeout flush of partial records.
module tx_framer #(
    parameter int CHNL_ALIGN      = 4,
    parameter int MAX_IDLE_CYCLES = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_val,
    output logic                    i_rdy,
    input  logic [31:0]             i_data,
    input  logic                    i_last,
    output logic                    o_val,
    input  logic                    o_rdy,
    output logic [32*CHNL_ALIGN-1:0] o_data
);

    localparam int NW = CHNL_ALIGN - 1;
    localparam int IW = (MAX_IDLE_CYCLES > 0) ? $clog2(MAX_IDLE_CYCLES + 1) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(MAX_IDLE_CYCLES);
    localparam logic [7:0]    CNT_FULL = 8'(CHNL_ALIGN - 1);
    localparam logic          FLUSH_EN = (MAX_IDLE_CYCLES != 0);

    typedef enum logic {
        S_FILL,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [32*NW-1:0] pay_q;
    logic [31:0]      hdr_q;
    logic [7:0]       seq_q;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_inc;
    logic [IW-1:0]    idle_q;
    logic             in_msg_q;
    logic             som_q;
    logic             som_cur;
    logic             up_q;
    logic             acc;
    logic             close_word;
    logic             flush;

    assign i_rdy   = up_q && (state == S_FILL);
    assign o_val   = (state == S_OUT);
    assign o_data  = {pay_q, hdr_q};
    assign acc     = i_val && i_rdy;
    assign cnt_inc = cnt_q + 8'd1;

    // SOM belongs to the record's first word; later words reuse the latched value.
    assign som_cur    = (cnt_q == 8'd0) ? !in_msg_q : som_q;
    assign close_word = acc && ((cnt_inc == CNT_FULL) || i_last);
    assign flush      = (state == S_FILL) && !i_val && (cnt_q != 8'd0) && FLUSH_EN
                        && (idle_q >= IDLE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL: begin
                if (close_word || flush) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (o_rdy) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pay_q    <= '0;
            hdr_q    <= '0;
            seq_q    <= '0;
            cnt_q    <= '0;
            idle_q   <= '0;
            in_msg_q <= 1'b0;
            som_q    <= 1'b0;
            up_q     <= 1'b0;
        end else begin
            up_q <= 1'b1;
            case (state)
                S_FILL: begin
                    if (acc) begin
                        for (int j = 0; j < NW; j++) begin
                            if (cnt_q == 8'(j)) begin
                                pay_q[32*j +: 32] <= i_data;
                            end
                        end
                        cnt_q    <= cnt_inc;
                        idle_q   <= '0;
                        in_msg_q <= !i_last;
                        som_q    <= som_cur;
                        if (close_word) begin
                            hdr_q <= {8'hA5, seq_q, som_cur, i_last, 6'b0, cnt_inc};
                        end
                    end else if (flush) begin
                        hdr_q <= {8'hA5, seq_q, som_q, 1'b0, 6'b0, cnt_q};
                    end else if (!i_val && (cnt_q != 8'd0) && (idle_q < IDLE_MAX)) begin
                        idle_q <= idle_q + IW'(1);
                    end
                end
                S_OUT: begin
                    if (o_rdy) begin
                        seq_q  <= seq_q + 8'd1;
                        pay_q  <= '0;
                        hdr_q  <= '0;
                        cnt_q  <= '0;
                        idle_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_framer.sv
// tb/tb_tx_framer.sv - scoreboard bench for tx_framer with a queue-based record model
// Stimulus pushes expected records; an independent monitor pops them on each output handshake.
module tb_tx_framer;

    localparam int A    = 4;
    localparam int MAXI = 8;
    localparam int W    = 32 * A;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_val = 1'b0;
    logic          i_rdy;
    logic [31:0]   i_data = '0;
    logic          i_last = 1'b0;
    logic          o_val;
    logic          o_rdy = 1'b0;
    logic [W-1:0]  o_data;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0]  exp_q[$];
    logic [31:0]   pend[$];
    logic [7:0]    seq_m = 8'd0;
    bit            in_msg = 1'b0;
    bit            som_m = 1'b0;
    int            idle_m = 0;
    int            ordy_mode = 1;

    logic [W-1:0]  hold_d;
    bit            hold = 1'b0;

    always #5 clk = ~clk;

    tx_framer #(.CHNL_ALIGN(A), .MAX_IDLE_CYCLES(MAXI)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_val  (i_val),
        .i_rdy  (i_rdy),
        .i_data (i_data),
        .i_last (i_last),
        .o_val  (o_val),
        .o_rdy  (o_rdy),
        .o_data (o_data)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic close_rec(input bit eom);
        logic [W-1:0] e;
        e = '0;
        e[31:0] = {8'hA5, seq_m, som_m, eom, 6'b0, 8'(pend.size())};
        foreach (pend[j]) e[32*(j+1) +: 32] = pend[j];
        exp_q.push_back(e);
        seq_m  = seq_m + 8'd1;
        idle_m = 0;
        pend.delete();
    endtask

    task automatic model_step(input bit v, input bit acc, input logic [31:0] d, input bit l);
        if (acc) begin
            pend.push_back(d);
            if (pend.size() == 1) som_m = !in_msg;
            in_msg = !l;
            idle_m = 0;
            if (pend.size() == A - 1 || l) close_rec(l);
        end else if (!v && pend.size() > 0) begin
            if (idle_m >= MAXI) close_rec(1'b0);
            else idle_m++;
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input bit l, output bit acc);
        @(negedge clk);
        i_val  = v;
        i_data = d;
        i_last = l;
        #1;
        acc = v && i_rdy;
        model_step(v, acc, d, l);
    endtask

    task automatic send_word(input logic [31:0] d, input bit l);
        bit acc;
        int tries;
        tries = 0;
        do begin
            cycle(1'b1, d, l, acc);
            tries++;
        end while (!acc && tries < 500);
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: word %h not accepted within 500 cycles", d);
        end
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        repeat (n) cycle(1'b0, 32'd0, 1'b0, acc);
    endtask

    always @(negedge clk) begin
        o_rdy = (ordy_mode == 1) || ((ordy_mode == 2) && ($urandom_range(0, 1) == 1));
    end

    always @(negedge clk) begin
        #2;
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_val", W'(o_val), W'(1));
                chk("hold_data", o_data, hold_d);
            end
            if (o_val && o_rdy) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL record_unexpected: got %h expected no record", o_data);
                end else begin
                    chk("record", o_data, exp_q.pop_front());
                end
                hold = 1'b0;
            end else begin
                hold   = o_val;
                hold_d = o_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int gap;
        bit lst;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_o_val", W'(o_val), W'(0));
        chk("rst_i_rdy", W'(i_rdy), W'(0));
        chk("rst_o_data", o_data, W'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rel_i_rdy", W'(i_rdy), W'(1));

        // three-word message fills one record exactly
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd3, 1'b1);
        cycle(1'b0, 32'd0, 1'b0, acc);
        chk("t1_o_val", W'(o_val), W'(1));
        chk("t1_rec", o_data, {32'd3, 32'd2, 32'd1, 32'hA500C003});
        idle_cycles(3);

        // five-word message spans two records
        for (int k = 10; k <= 14; k++) send_word(32'(k), k == 14);
        idle_cycles(4);

        // backpressure with input pending
        ordy_mode = 0;
        send_word(32'd21, 1'b0);
        send_word(32'd22, 1'b1);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 32'd23, 1'b1, acc);
            chk("bp_i_rdy", W'(i_rdy), W'(0));
            chk("bp_o_val", W'(o_val), W'(1));
        end
        ordy_mode = 1;
        send_word(32'd23, 1'b1);
        idle_cycles(3);

        // idle flush of a partial record
        send_word(32'd7, 1'b0);
        idle_cycles(9);
        chk("flush_not_yet", W'(o_val), W'(0));
        cycle(1'b0, 32'd0, 1'b0, acc);
        chk("flush_o_val", W'(o_val), W'(1));
        idle_cycles(3);
        send_word(32'd8, 1'b1);
        idle_cycles(3);

        // 256 single-word messages wrap seq
        ordy_mode = 2;
        for (int k = 0; k < 256; k++) send_word(32'(k + 32'h100), 1'b1);
        ordy_mode = 1;
        idle_cycles(4);

        // reset while a record is presented
        ordy_mode = 0;
        send_word(32'd31, 1'b0);
        send_word(32'd32, 1'b1);
        cycle(1'b0, 32'd0, 1'b0, acc);
        chk("r6_o_val", W'(o_val), W'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("r6_rst_o_val", W'(o_val), W'(0));
        chk("r6_rst_i_rdy", W'(i_rdy), W'(0));
        exp_q.delete();
        pend.delete();
        seq_m  = 8'd0;
        in_msg = 1'b0;
        idle_m = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("r6_rel_i_rdy", W'(i_rdy), W'(1));
        ordy_mode = 1;
        send_word(32'd41, 1'b1);
        cycle(1'b0, 32'd0, 1'b0, acc);
        chk("r6_rec", o_data, {32'd0, 32'd0, 32'd41, 32'hA500C001});
        idle_cycles(2);

        // randomized traffic with random backpressure and gaps around the flush threshold
        ordy_mode = 2;
        for (int k = 0; k < 300; k++) begin
            lst = ($urandom_range(0, 3) == 0);
            send_word($urandom, lst);
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 2);
            idle_cycles(gap);
        end

        ordy_mode = 1;
        idle_cycles(40);
        chk("drain", W'(exp_q.size() + pend.size()), W'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
